// File: rtl/stage2_bias_add.sv
// fsincos stage 2: x = a + bias with alignment, add/sub, normalisation and RNE rounding.
// Two register stages: A aligns the smaller operand, B adds, normalises and rounds.
module stage2_bias_add #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_st1_valid,
  input  logic                  i_sign_a,
  input  logic [EXP_WIDTH-1:0]  i_exp_a,
  input  logic [FRAC_WIDTH-1:0] i_frac_a,
  input  logic                  i_sign_bias,
  input  logic [EXP_WIDTH-1:0]  i_exp_bias,
  input  logic [FRAC_WIDTH-1:0] i_frac_bias,
  input  logic                  i_sincos_proced,
  input  logic                  i_result_sign_flip,
  input  logic                  i_zero_flag,
  output logic                  o_st2_sign_x,
  output logic [EXP_WIDTH-1:0]  o_st2_exp_x,
  output logic [FRAC_WIDTH-1:0] o_st2_frac_x,
  output logic                  o_st2_sincos_proced,
  output logic                  o_st2_result_sign_flip,
  output logic                  o_st2_zero_flag,
  output logic                  o_st2_valid
);

  localparam int MW  = FRAC_WIDTH + 3;
  localparam int LZW = $clog2(MW + 1);
  localparam int XW  = EXP_WIDTH + 2;
  localparam logic [XW-1:0] EMAX = XW'((1 << EXP_WIDTH) - 2);

  // ---------------- stage A: compare and align ----------------
  logic                  a_ge;
  logic                  sign_big;
  logic [EXP_WIDTH-1:0]  exp_big, exp_small, shift_d;
  logic [FRAC_WIDTH-1:0] frac_big, frac_small;
  logic [2*MW-1:0]       wide;
  logic [MW-1:0]         small_al;

  always_comb begin
    a_ge = {i_exp_a, i_frac_a} >= {i_exp_bias, i_frac_bias};
    if (a_ge) begin
      sign_big   = i_sign_a;
      exp_big    = i_exp_a;
      frac_big   = i_frac_a;
      exp_small  = i_exp_bias;
      frac_small = i_frac_bias;
    end else begin
      sign_big   = i_sign_bias;
      exp_big    = i_exp_bias;
      frac_big   = i_frac_bias;
      exp_small  = i_exp_a;
      frac_small = i_frac_a;
    end
    shift_d = exp_big - exp_small;
    // Lower half of the wide vector catches every bit shifted past the sticky position.
    wide = {frac_small, 3'b000, {MW{1'b0}}} >> shift_d;
    if (int'(shift_d) >= FRAC_WIDTH + 2)
      small_al = {{(MW-1){1'b0}}, |frac_small};
    else
      small_al = {wide[2*MW-1:MW+1], wide[MW] | (|wide[MW-1:0])};
  end

  logic                  sa_valid;
  logic                  sa_sign_big;
  logic [EXP_WIDTH-1:0]  sa_exp_big;
  logic [FRAC_WIDTH-1:0] sa_frac_big;
  logic [MW-1:0]         sa_small;
  logic                  sa_eff_sub, sa_a_zero, sa_b_zero;
  logic                  sa_sincos, sa_flip, sa_zero_flag;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sa_valid     <= 1'b0;
      sa_sign_big  <= 1'b0;
      sa_exp_big   <= '0;
      sa_frac_big  <= '0;
      sa_small     <= '0;
      sa_eff_sub   <= 1'b0;
      sa_a_zero    <= 1'b0;
      sa_b_zero    <= 1'b0;
      sa_sincos    <= 1'b0;
      sa_flip      <= 1'b0;
      sa_zero_flag <= 1'b0;
    end else begin
      sa_valid <= i_st1_valid;
      if (i_st1_valid) begin
        sa_sign_big  <= sign_big;
        sa_exp_big   <= exp_big;
        sa_frac_big  <= frac_big;
        sa_small     <= small_al;
        sa_eff_sub   <= i_sign_a ^ i_sign_bias;
        sa_a_zero    <= (i_exp_a == '0);
        sa_b_zero    <= (i_exp_bias == '0);
        sa_sincos    <= i_sincos_proced;
        sa_flip      <= i_result_sign_flip;
        sa_zero_flag <= i_zero_flag;
      end
    end
  end

  // ---------------- stage B: add/sub, normalise, round ----------------
  logic [MW:0]           big_ext, sum;
  logic [MW-1:0]         diff, norm;
  logic [LZW-1:0]        lzc;
  logic                  lz_found;
  logic [XW-1:0]         exp_n, exp_r;
  logic [FRAC_WIDTH:0]   rnd;
  logic [FRAC_WIDTH-1:0] frac_r;
  logic                  inc, underflow;
  logic                  nx_sign;
  logic [EXP_WIDTH-1:0]  nx_exp;
  logic [FRAC_WIDTH-1:0] nx_frac;

  always_comb begin
    big_ext  = {1'b0, sa_frac_big, 3'b000};
    sum      = big_ext + {1'b0, sa_small};
    diff     = big_ext[MW-1:0] - sa_small;
    lzc      = '0;
    lz_found = 1'b0;
    for (int i = MW - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (diff[i]) lz_found = 1'b1;
        else         lzc = lzc + LZW'(1);
      end
    end
    if (!sa_eff_sub) begin
      if (sum[MW]) begin
        norm  = {sum[MW:2], sum[1] | sum[0]};
        exp_n = {2'b00, sa_exp_big} + XW'(1);
      end else begin
        norm  = sum[MW-1:0];
        exp_n = {2'b00, sa_exp_big};
      end
    end else begin
      norm  = diff << lzc;
      exp_n = {2'b00, sa_exp_big} - XW'(lzc);
    end
    inc = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd = {1'b0, norm[MW-1:3]} + (FRAC_WIDTH+1)'(inc);
    if (rnd[FRAC_WIDTH]) begin
      frac_r = {1'b1, {(FRAC_WIDTH-1){1'b0}}};
      exp_r  = exp_n + XW'(1);
    end else begin
      frac_r = rnd[FRAC_WIDTH-1:0];
      exp_r  = exp_n;
    end
    underflow = sa_eff_sub && (XW'(lzc) >= {2'b00, sa_exp_big});

    nx_sign = 1'b0;
    nx_exp  = '0;
    nx_frac = '0;
    if (sa_zero_flag || (sa_a_zero && sa_b_zero)) begin
      nx_sign = 1'b0;
    end else if (sa_a_zero || sa_b_zero) begin
      // the non-zero operand always wins the magnitude compare, so big is it verbatim
      nx_sign = sa_sign_big;
      nx_exp  = sa_exp_big;
      nx_frac = sa_frac_big;
    end else if ((sa_eff_sub && diff == '0) || underflow) begin
      nx_sign = 1'b0;
    end else if (exp_r > EMAX) begin
      nx_sign = sa_sign_big;
      nx_exp  = EMAX[EXP_WIDTH-1:0];
      nx_frac = '1;
    end else begin
      nx_sign = sa_sign_big;
      nx_exp  = exp_r[EXP_WIDTH-1:0];
      nx_frac = frac_r;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_st2_valid            <= 1'b0;
      o_st2_sign_x           <= 1'b0;
      o_st2_exp_x            <= '0;
      o_st2_frac_x           <= '0;
      o_st2_sincos_proced    <= 1'b0;
      o_st2_result_sign_flip <= 1'b0;
      o_st2_zero_flag        <= 1'b0;
    end else begin
      o_st2_valid <= sa_valid;
      if (sa_valid) begin
        o_st2_sign_x           <= nx_sign;
        o_st2_exp_x            <= nx_exp;
        o_st2_frac_x           <= nx_frac;
        o_st2_sincos_proced    <= sa_sincos;
        o_st2_result_sign_flip <= sa_flip;
        o_st2_zero_flag        <= sa_zero_flag;
      end
    end
  end

endmodule

// File: tb/tb_stage2_bias_add.sv
// Scoreboard bench for stage2_bias_add: directed vectors with hand-computed sums,
// checked by an independent monitor on the falling edge.
module tb_stage2_bias_add;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_st1_valid = 1'b0;
  logic        i_sign_a = 1'b0, i_sign_bias = 1'b0;
  logic [7:0]  i_exp_a = '0, i_exp_bias = '0;
  logic [31:0] i_frac_a = '0, i_frac_bias = '0;
  logic        i_sincos_proced = 1'b0, i_result_sign_flip = 1'b0, i_zero_flag = 1'b0;
  logic        o_st2_sign_x;
  logic [7:0]  o_st2_exp_x;
  logic [31:0] o_st2_frac_x;
  logic        o_st2_sincos_proced, o_st2_result_sign_flip, o_st2_zero_flag, o_st2_valid;

  stage2_bias_add #(.EXP_WIDTH(8), .FRAC_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_st1_valid(i_st1_valid),
    .i_sign_a(i_sign_a), .i_exp_a(i_exp_a), .i_frac_a(i_frac_a),
    .i_sign_bias(i_sign_bias), .i_exp_bias(i_exp_bias), .i_frac_bias(i_frac_bias),
    .i_sincos_proced(i_sincos_proced), .i_result_sign_flip(i_result_sign_flip),
    .i_zero_flag(i_zero_flag),
    .o_st2_sign_x(o_st2_sign_x), .o_st2_exp_x(o_st2_exp_x), .o_st2_frac_x(o_st2_frac_x),
    .o_st2_sincos_proced(o_st2_sincos_proced), .o_st2_result_sign_flip(o_st2_result_sign_flip),
    .o_st2_zero_flag(o_st2_zero_flag), .o_st2_valid(o_st2_valid)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [43:0] word;   // {sign, exp, frac, sincos, flip, zero}
    int          issue;
  } exp_t;

  exp_t q_exp[$];
  int   total = 0;
  int   bad = 0;

  function automatic logic [43:0] out_word();
    return {o_st2_sign_x, o_st2_exp_x, o_st2_frac_x,
            o_st2_sincos_proced, o_st2_result_sign_flip, o_st2_zero_flag};
  endfunction

  // monitor: pops one expectation for every valid output
  always @(negedge i_clk) begin
    if (i_rstn && o_st2_valid) begin
      total++;
      if (q_exp.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: got word=%h with no operand outstanding (cyc %0d)", out_word(), cyc);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        if (out_word() !== e.word) begin
          bad++;
          $display("FAIL result: got %h want %h (cyc %0d)", out_word(), e.word, cyc);
        end
        total++;
        if (cyc != e.issue + 2) begin
          bad++;
          $display("FAIL latency: got %0d cycles want 2", cyc - e.issue);
        end
      end
    end
  end

  task automatic send(input logic sa, input logic [7:0] ea, input logic [31:0] fa,
                      input logic sb, input logic [7:0] eb, input logic [31:0] fb,
                      input logic sc, input logic fl, input logic zf,
                      input logic es, input logic [7:0] ee, input logic [31:0] ef);
    exp_t e;
    @(negedge i_clk);
    i_st1_valid = 1'b1;
    i_sign_a = sa;    i_exp_a = ea;    i_frac_a = fa;
    i_sign_bias = sb; i_exp_bias = eb; i_frac_bias = fb;
    i_sincos_proced = sc; i_result_sign_flip = fl; i_zero_flag = zf;
    e.word  = {es, ee, ef, sc, fl, zf};
    e.issue = cyc;
    q_exp.push_back(e);
  endtask

  task automatic idle();
    @(negedge i_clk);
    i_st1_valid = 1'b0;
    i_sign_a = 1'b1; i_exp_a = 8'hAA; i_frac_a = 32'hDEAD_BEEF;
    i_sincos_proced = 1'b1; i_result_sign_flip = 1'b1; i_zero_flag = 1'b1;
  endtask

  task automatic check(input string name, input logic [44:0] got, input logic [44:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q_exp.size() > 0; i++) @(negedge i_clk);
    total++;
    if (q_exp.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d outstanding want 0", q_exp.size());
    end
  endtask

  int vcount;

  initial begin
    // reset state
    repeat (3) @(negedge i_clk);
    check("reset_outputs", {o_st2_valid, out_word()}, 45'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(negedge i_clk);
    check("post_release_idle", {o_st2_valid, out_word()}, 45'd0);

    // four back-to-back with alternating sideband
    send(0, 127, 32'h8000_0000, 0, 126, 32'h8000_0000, 0, 1, 0,  0, 127, 32'hC000_0000);
    send(0, 127, 32'h8000_0000, 1, 126, 32'hC000_0000, 1, 0, 0,  0, 125, 32'h8000_0000);
    send(0, 127, 32'hC000_0000, 0, 127, 32'hC000_0000, 0, 1, 0,  0, 128, 32'hC000_0000);
    send(0, 127, 32'h8000_0000, 0,  95, 32'hC000_0000, 1, 0, 0,  0, 127, 32'h8000_0001);
    idle();
    @(negedge i_clk);
    @(negedge i_clk);
    check("hold_gap1", {o_st2_valid, out_word()}, {1'b0, 1'b0, 8'd127, 32'h8000_0001, 3'b100});
    @(negedge i_clk);
    check("hold_gap2", {o_st2_valid, out_word()}, {1'b0, 1'b0, 8'd127, 32'h8000_0001, 3'b100});

    // rounding, cancellation, zero handling, saturation, underflow
    send(0, 127, 32'h8000_0000, 0,  95, 32'h8000_0000, 0, 0, 0,  0, 127, 32'h8000_0000);
    send(0, 127, 32'h8000_0000, 1, 127, 32'h8000_0000, 1, 1, 0,  0,   0, 32'h0000_0000);
    send(0, 127, 32'h8000_0000, 0, 126, 32'h8000_0000, 1, 1, 1,  0,   0, 32'h0000_0000);
    send(0,   0, 32'h1234_5678, 1, 126, 32'h8000_0000, 0, 1, 0,  1, 126, 32'h8000_0000);
    send(0, 254, 32'hFFFF_FFFF, 0, 254, 32'hFFFF_FFFF, 1, 0, 0,  0, 254, 32'hFFFF_FFFF);
    send(0,   1, 32'hC000_0000, 1,   1, 32'h8000_0000, 0, 0, 0,  0,   0, 32'h0000_0000);
    send(0, 126, 32'h8000_0000, 1, 127, 32'h8000_0000, 1, 0, 0,  1, 126, 32'h8000_0000);
    send(0, 127, 32'h8000_0000, 0,  95, 32'h8000_0001, 0, 1, 0,  0, 127, 32'h8000_0001);
    send(0, 127, 32'h8000_0001, 0,  95, 32'h8000_0000, 1, 1, 0,  0, 127, 32'h8000_0002);
    send(1, 127, 32'h8000_0000, 1, 126, 32'h8000_0000, 0, 0, 0,  1, 127, 32'hC000_0000);
    idle();
    drain();

    // reset while an operand sits in stage A
    send(0, 127, 32'hC000_0000, 0, 127, 32'hC000_0000, 1, 1, 0,  0, 128, 32'hC000_0000);
    @(negedge i_clk);
    i_st1_valid = 1'b0;
    i_rstn = 1'b0;
    q_exp.delete();
    #1;
    check("async_reset_clear", {o_st2_valid, out_word()}, 45'd0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      if (o_st2_valid) vcount++;
    end
    check("no_stale_valid", 45'(vcount), 45'd0);
    check("outputs_after_reset", {o_st2_valid, out_word()}, 45'd0);

    send(0, 127, 32'h8000_0000, 0, 126, 32'h8000_0000, 1, 0, 1,  0,   0, 32'h0000_0000);
    send(0, 127, 32'hC000_0000, 0, 127, 32'hC000_0000, 0, 1, 0,  0, 128, 32'hC000_0000);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
